alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: registered ALU with iterative unsigned multiply / divide.
//
// Single-cycle ops finish at the accept edge. multu/divu run WIDTH
// shift-add / restoring-division iterations and present {hi_out, alu_out}.
// A result is flagged by a one-cycle out_valid pulse. Between pulses the
// result outputs hold their values.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operation request
//   in_ready     block can accept a request this cycle
//   alu_ctrl     operation select (4 bits)
//   input_a      operand A (WIDTH)
//   input_b      operand B (WIDTH)
//   shamt        shift amount (SHAMT_W)
//   out_valid    one-cycle pulse, result outputs updated
//   alu_out      result (LO / quotient for mul/div)
//   hi_out       HI of product or remainder; 0 for other ops
//   zero         alu_out == 0
//   overflow     signed overflow on add/sub
//   div_by_zero  divu issued with input_b == 0
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic               zero,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   operand;   // multiplicand (A) or divisor (B)
  logic [WIDTH-1:0]   acc_hi;    // partial product high / remainder
  logic [WIDTH-1:0]   acc_lo;    // multiplier bits / dividend-quotient
  logic [SHAMT_W-1:0] cnt;

  // DONE is the result cycle of a multi-cycle op; it can accept like IDLE.
  assign in_ready = (state == IDLE) || (state == DONE);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_ovf, sc_dbz;

  assign sum  = input_a + input_b;
  assign diff = input_a - input_b;

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        sc_lo  = sum;
        // Same-sign operands producing a different-sign sum.
        sc_ovf = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                 (sum[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                 (diff[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_NOT:  sc_lo = ~input_a;
      OP_SLL:  sc_lo = input_a << shamt;
      OP_SRL:  sc_lo = input_a >> shamt;
      OP_AND:  sc_lo = input_a & input_b;
      OP_OR:   sc_lo = input_a | input_b;
      OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
      OP_SRA:  sc_lo = $signed(input_a) >>> shamt;
      OP_XOR:  sc_lo = input_a ^ input_b;
      OP_NOR:  sc_lo = ~(input_a | input_b);
      OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (input_a < input_b)};
      OP_DIVU: begin
        // Only reaches here with input_b == 0; nonzero divisors iterate.
        sc_lo  = '1;
        sc_hi  = input_a;
        sc_dbz = 1'b1;
      end
      default: sc_lo = '0;
    endcase
  end

  // ---------------- one multiply / divide iteration ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the {carry, hi, lo} triple right by one.
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring division: bring the next dividend bit into the remainder,
    // subtract the divisor if it fits and shift in the quotient bit.
    div_shift   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff    = div_shift - {1'b0, operand};
    div_ge      = (div_shift >= {1'b0, operand});
    div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_next = {acc_lo[WIDTH-2:0], div_ge};
  end

  // ---------------- control FSM and result registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      operand     <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      alu_out     <= '0;
      hi_out      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (in_valid) begin
            if (alu_ctrl == OP_MULU) begin
              operand <= input_a;
              acc_hi  <= '0;
              acc_lo  <= input_b;
              cnt     <= '0;
              state   <= MUL;
            end else if ((alu_ctrl == OP_DIVU) && (input_b != '0)) begin
              operand <= input_b;
              acc_hi  <= '0;
              acc_lo  <= input_a;
              cnt     <= '0;
              state   <= DIV;
            end else begin
              alu_out     <= sc_lo;
              hi_out      <= sc_hi;
              zero        <= (sc_lo == '0);
              overflow    <= sc_ovf;
              div_by_zero <= sc_dbz;
              out_valid   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_next;
          acc_lo <= mul_lo_next;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == LAST_ITER) begin
            alu_out     <= mul_lo_next;
            hi_out      <= mul_hi_next;
            zero        <= (mul_lo_next == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DIV: begin
          acc_hi <= div_hi_next;
          acc_lo <= div_lo_next;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == LAST_ITER) begin
            alu_out     <= div_lo_next;
            hi_out      <= div_hi_next;
            zero        <= (div_lo_next == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
// Expected results come from a wide-integer reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv32 = 1'b0, iv8 = 1'b0;
  logic [3:0]  ctrl_s = '0;
  logic [31:0] a_s = '0, b_s = '0;
  logic [4:0]  sh_s = '0;

  logic        rdy32, ov32, z32, of32, dz32;
  logic [31:0] lo32, hi32;
  logic        rdy8, ov8, z8, of8, dz8;
  logic [7:0]  lo8, hi8;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32),
    .alu_ctrl(ctrl_s), .input_a(a_s), .input_b(b_s), .shamt(sh_s),
    .out_valid(ov32), .alu_out(lo32), .hi_out(hi32), .zero(z32),
    .overflow(of32), .div_by_zero(dz32)
  );

  alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
    .alu_ctrl(ctrl_s), .input_a(a_s[7:0]), .input_b(b_s[7:0]), .shamt(sh_s[2:0]),
    .out_valid(ov8), .alu_out(lo8), .hi_out(hi8), .zero(z8),
    .overflow(of8), .div_by_zero(dz8)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    logic        dbz;
    int          lat;
  } res_t;

  typedef struct {
    logic        rdy;
    logic        ov;
    logic        z;
    logic        of;
    logic        dz;
    logic [31:0] lo;
    logic [31:0] hi;
  } obs_t;

  // Reference model: plain wide arithmetic on w-bit values.
  function automatic res_t model(int w, logic [3:0] c, logic [31:0] a0,
                                 logic [31:0] b0, logic [4:0] sh0);
    res_t        r;
    logic [63:0] mask, a, b, v, sbit, prod;
    longint      sa, sb, s_res, smax, smin;
    int          s;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'd0, a0} & mask;
    b    = {32'd0, b0} & mask;
    s    = int'(sh0) % w;
    sbit = 64'd1 << (w - 1);
    sa   = longint'(a ^ sbit) - longint'(sbit);
    sb   = longint'(b ^ sbit) - longint'(sbit);
    smax = longint'(sbit) - 1;
    smin = -longint'(sbit);
    r.hi = '0; r.ovf = 1'b0; r.dbz = 1'b0; r.lat = 1;
    v = '0;
    case (c)
      4'd0:  begin v = a + b; s_res = sa + sb; r.ovf = (s_res > smax) || (s_res < smin); end
      4'd1:  begin v = a - b; s_res = sa - sb; r.ovf = (s_res > smax) || (s_res < smin); end
      4'd2:  v = ~a;
      4'd3:  v = a << s;
      4'd4:  v = a >> s;
      4'd5:  v = a & b;
      4'd6:  v = a | b;
      4'd7:  v = {63'd0, sa < sb};
      4'd8:  v = 64'(sa >>> s);
      4'd9:  v = a ^ b;
      4'd10: v = ~(a | b);
      4'd11: v = {63'd0, a < b};
      4'd12: begin
        prod  = a * b;
        v     = prod;
        r.hi  = 32'((prod >> w) & mask);
        r.lat = w + 1;
      end
      4'd13: begin
        if (b == 64'd0) begin
          v = mask; r.hi = 32'(a); r.dbz = 1'b1;
        end else begin
          v = a / b; r.hi = 32'(a % b); r.lat = w + 1;
        end
      end
      default: v = '0;
    endcase
    r.lo = 32'(v & mask);
    return r;
  endfunction

  function automatic obs_t sample(int w);
    obs_t o;
    if (w == 32) begin
      o.rdy = rdy32; o.ov = ov32; o.z = z32; o.of = of32; o.dz = dz32;
      o.lo = lo32; o.hi = hi32;
    end else begin
      o.rdy = rdy8; o.ov = ov8; o.z = z8; o.of = of8; o.dz = dz8;
      o.lo = {24'd0, lo8}; o.hi = {24'd0, hi8};
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_valid(input int w, input logic val);
    if (w == 32) iv32 = val; else iv8 = val;
  endtask

  // Issue one operation, wait (bounded) for its result and check everything.
  // poke: hold in_valid for a few busy cycles to prove it is ignored.
  task automatic run_op(input int w, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input bit poke, input string tag);
    res_t e;
    obs_t o;
    int   lat, n;
    e = model(w, c, a, b, sh);
    n = 0;
    o = sample(w);
    while (!o.rdy && n < 100) begin
      @(posedge clk); #1; n++; o = sample(w);
    end
    chk({tag, ".ready"}, o.rdy, 1);
    ctrl_s = c; a_s = a; b_s = b; sh_s = sh;
    drive_valid(w, 1'b1);
    @(posedge clk); #1;
    iv32 = 1'b0; iv8 = 1'b0;
    lat = 1;
    o = sample(w);
    while (!o.ov && lat < 100) begin
      chk({tag, ".busy_ready"}, o.rdy, 0);
      if (poke && lat < 5) begin
        ctrl_s = 4'd0; a_s = $urandom; b_s = $urandom;
        drive_valid(w, 1'b1);
      end else begin
        iv32 = 1'b0; iv8 = 1'b0;
      end
      @(posedge clk); #1; lat++; o = sample(w);
    end
    iv32 = 1'b0; iv8 = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
    chk({tag, ".alu_out"}, o.lo, e.lo);
    chk({tag, ".hi_out"}, o.hi, e.hi);
    chk({tag, ".zero"}, o.z, (e.lo == 32'd0));
    chk({tag, ".overflow"}, o.of, e.ovf);
    chk({tag, ".div_by_zero"}, o.dz, e.dbz);
    $display("[TB] %s w=%0d ctrl=%0h a=%0h b=%0h sh=%0d -> lo=%0h hi=%0h lat=%0d",
             tag, w, c, a, b, sh, o.lo, o.hi, lat);
    @(posedge clk); #1;
    o = sample(w);
    chk({tag, ".pulse_end"}, o.ov, 0);
    chk({tag, ".hold"}, o.lo, e.lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   stray;

    // Reset values for both widths.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = sample(32);
    chk("reset32.ready", o.rdy, 1);
    chk("reset32.out_valid", o.ov, 0);
    chk("reset32.alu_out", o.lo, 0);
    chk("reset32.hi_out", o.hi, 0);
    chk("reset32.flags", {o.z, o.of, o.dz}, 0);
    o = sample(8);
    chk("reset8.ready", o.rdy, 1);
    chk("reset8.out_valid", o.ov, 0);
    chk("reset8.alu_out", o.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    ctrl_s = 4'd12; a_s = 32'hFFFF_FFFF; b_s = 32'hFFFF_FFFF; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midmul.busy", rdy32, 0);
    rst_n = 1'b0;
    #1;
    chk("midmul_rst.ready", rdy32, 1);
    chk("midmul_rst.out_valid", ov32, 0);
    chk("midmul_rst.alu_out", lo32, 0);
    chk("midmul_rst.hi_out", hi32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) stray++;
    end
    chk("midmul_rst.stray_valid", 64'(stray), 0);
    $display("[TB] reset mid-multu: stray out_valid pulses=%0d", stray);

    // Add overflow, sub to zero.
    run_op(32, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, "add_ovf");
    run_op(32, 4'd1, 32'd5, 32'd5, 5'd0, 1'b0, "sub_zero");

    // Back-to-back slt then sltu.
    ctrl_s = 4'd7; a_s = 32'hFFFF_FFFF; b_s = 32'd1; iv32 = 1'b1;
    @(posedge clk); #1;
    chk("b2b.slt_valid", ov32, 1);
    chk("b2b.slt_out", lo32, 1);
    chk("b2b.ready", rdy32, 1);
    ctrl_s = 4'd11;
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("b2b.sltu_valid", ov32, 1);
    chk("b2b.sltu_out", lo32, 0);
    chk("b2b.sltu_zero", z32, 1);
    $display("[TB] back-to-back slt/sltu -> sltu lo=%0h valid=%0b", lo32, ov32);
    @(posedge clk); #1;
    chk("b2b.pulse_end", ov32, 0);

    // Shifts.
    run_op(32, 4'd3, 32'h0000_0001, 32'd0, 5'd0, 1'b0, "sll0");
    run_op(32, 4'd4, 32'h8000_0000, 32'd0, 5'd31, 1'b0, "srl31");
    run_op(32, 4'd8, 32'h8000_0000, 32'd0, 5'd4, 1'b0, "sra4");

    // Multiply with ignored requests while busy.
    run_op(32, 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1, "multu_max");

    // Divide, including divide by zero.
    run_op(32, 4'd13, 32'd100, 32'd7, 5'd0, 1'b0, "divu_100_7");
    run_op(32, 4'd13, 32'h1234, 32'd0, 5'd0, 1'b0, "divu_by0");

    // 8-bit instance.
    run_op(8, 4'd12, 32'hFF, 32'h02, 5'd0, 1'b0, "w8_multu");
    run_op(8, 4'd15, 32'hAB, 32'hCD, 5'd0, 1'b0, "w8_reserved");
    run_op(8, 4'd13, 32'hC8, 32'h07, 5'd0, 1'b1, "w8_divu");

    // Randomised operations against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      run_op(32, 4'($urandom_range(0, 15)), $urandom, rb,
             5'($urandom_range(0, 31)), 1'b0, "rand32");
    end
    for (int i = 0; i < 100; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      run_op(8, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)), rb,
             5'($urandom_range(0, 7)), 1'b0, "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
